// File: rtl/life_stream_stepper_if.sv
// Cell stream handshake between the Game-of-Life stepper and its neighbours.
// The upstream and downstream sides are grouped into one bundle.
interface life_stream_stepper_if;
  logic in_cell;
  logic in_valid;
  logic in_ready;
  logic out_cell;
  logic out_valid;
  logic out_ready;
  logic out_last;

  // Stepper side.
  modport slave (
    input  in_cell, in_valid, out_ready,
    output in_ready, out_cell, out_valid, out_last
  );

  // Environment side: upstream producer and downstream consumer.
  modport master (
    output in_cell, in_valid, out_ready,
    input  in_ready, out_cell, out_valid, out_last
  );
endinterface

// File: rtl/life_stream_stepper.sv
// Streaming Game-of-Life stepper: raster-order cells in, next generation out.
// A 2*WIDTH+3 window of history supplies all eight neighbours of the centre cell.
module full_adder_3_bit_to_4_bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [3:0] sum
);
  assign sum = {1'b0, a} + {1'b0, b};
endmodule

module life_stream_stepper #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  life_stream_stepper_if.slave s
);
  localparam int N    = WIDTH * HEIGHT;
  localparam int HL   = 2 * WIDTH + 3;
  localparam int CW   = $clog2(N + 1);
  localparam int COLW = $clog2(WIDTH);
  localparam int ROWW = $clog2(HEIGHT);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state;
  logic [HL-1:0]   hist, hist_nxt;
  logic [CW-1:0]   in_cnt;
  logic [COLW-1:0] col;
  logic [ROWW-1:0] row;
  logic            in_ready;
  logic            in_xfer, out_xfer, drain_step, shift, load, last_xfer;
  logic            lm, rm, um, dm;
  logic [2:0]      pa, pb;
  logic [3:0]      cnt;
  logic            centre, nxt;
  logic            hist_unused;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      FILL:    in_ready = 1'b1;
      RUN:     in_ready = !s.out_valid || s.out_ready;
      default: in_ready = 1'b0;
    endcase
  end
  assign s.in_ready = in_ready;

  assign in_xfer    = s.in_valid && in_ready;
  assign out_xfer   = s.out_valid && s.out_ready;
  // Once the out_last beat is loaded, DRAIN only waits for it to leave.
  assign drain_step = (state == DRAIN) && (!s.out_valid || s.out_ready) && !s.out_last;
  assign shift      = in_xfer || drain_step;
  assign load       = ((state == RUN) && in_xfer) || drain_step;
  assign last_xfer  = (state == DRAIN) && out_xfer && s.out_last;

  // Window as it will look after this shift; bit 0 is the newest cell.
  assign hist_nxt    = {hist[HL-2:0], in_xfer ? s.in_cell : 1'b0};
  // The oldest bit only ever falls off the end of the window.
  assign hist_unused = hist[HL-1];

  assign lm     = (col != '0);
  assign rm     = (col != COLW'(WIDTH - 1));
  assign um     = (row != '0);
  assign dm     = (row != ROWW'(HEIGHT - 1));
  assign centre = hist_nxt[WIDTH+1];

  assign pa = {2'b0, hist_nxt[2*WIDTH+2] & um & lm}
            + {2'b0, hist_nxt[2*WIDTH+1] & um}
            + {2'b0, hist_nxt[2*WIDTH]   & um & rm}
            + {2'b0, hist_nxt[WIDTH+2]   & lm}
            + {2'b0, hist_nxt[WIDTH]     & rm};
  assign pb = {2'b0, hist_nxt[2] & dm & lm}
            + {2'b0, hist_nxt[1] & dm}
            + {2'b0, hist_nxt[0] & dm & rm};

  full_adder_3_bit_to_4_bit u_add (.a(pa), .b(pb), .sum(cnt));

  assign nxt = (cnt == 4'd3) || (centre && (cnt == 4'd2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FILL;
      hist   <= '0;
      in_cnt <= '0;
      col    <= '0;
      row    <= '0;
    end else if (last_xfer) begin
      state  <= FILL;
      hist   <= '0;
      in_cnt <= '0;
      col    <= '0;
      row    <= '0;
    end else begin
      if (shift)   hist   <= hist_nxt;
      if (in_xfer) in_cnt <= in_cnt + 1'b1;
      if (state == FILL && in_xfer && in_cnt == CW'(WIDTH)) state <= RUN;
      if (state == RUN  && in_xfer && in_cnt == CW'(N - 1)) state <= DRAIN;
      if (load) begin
        if (col == COLW'(WIDTH - 1)) begin
          col <= '0;
          if (row != ROWW'(HEIGHT - 1)) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s.out_valid <= 1'b0;
      s.out_cell  <= 1'b0;
      s.out_last  <= 1'b0;
    end else if (load) begin
      s.out_valid <= 1'b1;
      s.out_cell  <= nxt;
      s.out_last  <= (row == ROWW'(HEIGHT - 1)) && (col == COLW'(WIDTH - 1));
    end else if (out_xfer) begin
      s.out_valid <= 1'b0;
      s.out_last  <= 1'b0;
    end
  end
endmodule

// File: doc/life_stream_stepper.md
Name: life_stream_stepper

Overview:
- Streaming Game-of-Life generation stepper. Accepts one grid's cells in raster order (row 0 col 0 first) and emits the next-generation cells in the same order.
- Sits upstream of the neighbour adder. It forms two 3-bit partial neighbour sums per cell, adds them in one full_adder_3_bit_to_4_bit instance, and applies the life rule.
- Cells outside the grid are dead. There is no wrap-around.

Parameters:
- WIDTH, 8, cells per row; minimum 2.
- HEIGHT, 8, rows per frame; minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_cell  input  1  current-generation cell, 1 = alive.
- in_valid  input  1  in_cell is valid.
- in_ready  output  1  the block accepts in_cell this cycle.
- out_cell  output  1  next-generation cell.
- out_valid  output  1  out_cell is valid.
- out_ready  input  1  downstream accepts out_cell this cycle.
- out_last  output  1  qualifies out_cell as cell (HEIGHT-1, WIDTH-1) of the frame.

Behaviour:
- Reset (asynchronous, active-low), values while asserted and on release:
  - Outputs: out_valid=0, out_cell=0, out_last=0, in_ready=1.
  - Internal: state=FILL, history register all 0, input index=0, output index=0.
  - Asserting reset mid-frame discards the partial frame. The first beat after release is treated as cell (0,0).
- Transfers: an input transfer occurs when in_valid&in_ready; an output transfer when out_valid&out_ready.
  - out_cell, out_last and out_valid are registered and hold stable while out_valid=1 and out_ready=0.
- History: a shift register of 2*WIDTH+3 bits, shifted by one on every input transfer or drain step.
  - Centre tap = cell k. Taps at offsets ±1, ±WIDTH, ±(WIDTH±1) give the 8 neighbours.
  - Taps are masked to 0 when col==0 (left taps) or col==WIDTH-1 (right taps).
  - Taps are masked to 0 when row==0 (upper taps) or row==HEIGHT-1 (lower taps).
- Count: partial A = above-left + above + above-right + left + right (0..5, 3 bits); partial B = the three below (0..3, 3 bits).
  - count = A+B, 4 bits, range 0..8.
- Rule: next = (count==3) | (alive & count==2).
- Latency: output k is computed after input k+WIDTH+1 is accepted, or during DRAIN for the last WIDTH+1 cells. out_valid rises the cycle after the enabling shift.
- State machine:
  - FILL: in_ready=1. The first WIDTH+1 input transfers only shift, with no output. Go to RUN after the (WIDTH+1)th transfer.
  - RUN: in_ready = !out_valid | out_ready, so a single output register is kept full. Each input transfer shifts and loads one output. After input WIDTH*HEIGHT-1 is accepted, go to DRAIN.
  - DRAIN: in_ready=0. Shift in 0 and load one output each time the output register is empty or being consumed. This produces the remaining WIDTH+1 outputs. The step that loads output WIDTH*HEIGHT-1 sets out_last=1.
    - When that output transfers, return to FILL with indices cleared.
    - in_ready stays 0 through that final transfer cycle and reasserts the next cycle.
- Simultaneous output transfer and input transfer in RUN: the new output is loaded in the same edge, so there is no bubble. Sustained throughput is 1 cell/cycle.
- in_valid=0 in RUN: no shift; out_valid drops after the pending output transfers.
- Back-to-back frames: the next frame's cell (0,0) is accepted the cycle after out_last transfers.

Test Plan:
- Empty 5x5 frame (WIDTH=HEIGHT=5), 25 zeros, out_ready=1 -> 25 zeros; out_last only on output 24; exactly 25 output transfers.
- Blinker: 5x5 with row 2 cols 1-3 alive -> output has col 2 rows 1-3 alive (indices 7,12,17), all else 0.
- Block still life: 4x4 cells (1,1),(1,2),(2,1),(2,2) alive -> identical frame out; corner-adjacent cells stay 0.
- Edge masking: 5x5 with only (0,4),(1,0),(1,4) alive -> no wrap births; (0,0) stays 0; all outputs 0.
- Backpressure: blinker with out_ready toggling 1,0,0,1 repeating and in_valid random -> same 25 outputs as the blinker case; out_cell stable while stalled; in_ready=0 whenever out_valid&!out_ready.
- Reset mid-frame: assert reset_n=0 after 12 inputs -> out_valid=0 and in_ready=1 immediately. A full blinker frame then yields the correct blinker result, followed by a second back-to-back frame with no idle cycle beyond the one after out_last.
